// File: rtl/tomasula_types.sv
// Shared Tomasulo datapath types: the reservation-station ALU word, the CDB
// result record, funct3 encodings and the RV32I R-type ALU function.
package tomasula_types;

    localparam int TAG_W  = 3;
    localparam int XLEN   = 32;

    typedef struct packed {
        logic [6:0]       op;
        logic [2:0]       funct3;
        logic             funct7;
        logic [XLEN-1:0]  src1_data;
        logic [XLEN-1:0]  src2_data;
        logic [TAG_W-1:0] tag;
    } alu_word;

    localparam int ALU_WORD_W = $bits(alu_word);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } cdb_result_t;

    localparam int CDB_RESULT_W = $bits(cdb_result_t);

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct7 is a single flag here: it selects sub over add and sra over srl.
    function automatic logic [XLEN-1:0] alu_exec(alu_word w);
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      sh;
        logic [XLEN-1:0] res;
        a   = w.src1_data;
        b   = w.src2_data;
        sh  = w.src2_data[4:0];
        res = '0;
        case (w.funct3)
            F3_ADD:  res = w.funct7 ? (a - b) : (a + b);
            F3_SLL:  res = a << sh;
            F3_SLT:  res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            F3_SLTU: res = {{(XLEN-1){1'b0}}, a < b};
            F3_XOR:  res = a ^ b;
            F3_SRL:  res = w.funct7 ? XLEN'($signed(a) >>> sh) : (a >> sh);
            F3_OR:   res = a | b;
            F3_AND:  res = a & b;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Small synchronous FIFO of CDB results; the head is read straight from the
// registered storage so it stays stable while the consumer stalls.
module alu_result_fifo
    import tomasula_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [CDB_RESULT_W-1:0]      push_data_i,
    input  logic                         pop_i,
    output logic [CDB_RESULT_W-1:0]      head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CDB_RESULT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [CNT_W-1:0]        count_q;
    logic                    do_push;
    logic                    do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is accepted when the head leaves on the same edge.
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Captures reservation-station execute pulses, round-robin issues one word per
// cycle into a registered ALU stage and delivers results over one CDB port.
module alu_issue_unit
    import tomasula_types::*;
#(
    parameter int NUM_RS     = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RS*ALU_WORD_W-1:0] rs_alu_data,
    input  logic [NUM_RS-1:0]            rs_start_exe,
    input  logic                         cdb_ready,
    output logic                         cdb_valid,
    output logic [TAG_W-1:0]             cdb_tag,
    output logic [XLEN-1:0]              cdb_data,
    output logic                         busy,
    output logic                         overflow_err
);

    localparam int RR_W  = $clog2(NUM_RS);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    alu_word          rs_word [NUM_RS];
    alu_word          pend_q  [NUM_RS];
    alu_word          pend_d  [NUM_RS];
    logic [NUM_RS-1:0] pend_valid_q, pend_valid_d;
    alu_word          stage_q, stage_d;
    logic             stage_valid_q, stage_valid_d;
    logic [RR_W-1:0]  rr_q, rr_d;
    logic             ovf_q, ovf_d;

    logic             grant_found;
    logic [RR_W-1:0]  grant_idx;
    logic             issue_en;
    logic             fifo_pop;
    logic             fifo_empty;
    logic             unused_fifo_full;
    logic [CNT_W-1:0] fifo_count;
    cdb_result_t      stage_result;
    cdb_result_t      fifo_head;
    logic             unused_op;

    for (genvar g = 0; g < NUM_RS; g++) begin : g_unpack
        assign rs_word[g] = rs_alu_data[g*ALU_WORD_W +: ALU_WORD_W];
    end

    // First pending slot at or after the round-robin pointer, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_RS; k++) begin
            if (!grant_found && pend_valid_q[(int'(rr_q) + k) % NUM_RS]) begin
                grant_found = 1'b1;
                grant_idx   = RR_W'((int'(rr_q) + k) % NUM_RS);
            end
        end
    end

    assign fifo_pop = cdb_valid && cdb_ready;
    // Room is counted after this edge's pop so the pipe sustains one result per cycle.
    assign issue_en = grant_found &&
        ((int'(fifo_count) + int'(stage_valid_q) - int'(fifo_pop)) < FIFO_DEPTH);

    always_comb begin
        pend_d        = pend_q;
        pend_valid_d  = pend_valid_q;
        stage_d       = stage_q;
        stage_valid_d = issue_en;
        rr_d          = rr_q;
        ovf_d         = ovf_q;
        if (issue_en) begin
            stage_d                 = pend_q[grant_idx];
            pend_valid_d[grant_idx] = 1'b0;
            rr_d = (int'(grant_idx) == NUM_RS - 1) ? '0 : grant_idx + 1'b1;
        end
        // Capture sees the slot already freed by an issue on the same edge.
        for (int i = 0; i < NUM_RS; i++) begin
            if (rs_start_exe[i]) begin
                if (pend_valid_d[i]) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_d[i]       = rs_word[i];
                    pend_valid_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_RS; i++) begin
                pend_q[i] <= '0;
            end
            pend_valid_q  <= '0;
            stage_q       <= '0;
            stage_valid_q <= 1'b0;
            rr_q          <= '0;
            ovf_q         <= 1'b0;
        end else begin
            pend_q        <= pend_d;
            pend_valid_q  <= pend_valid_d;
            stage_q       <= stage_d;
            stage_valid_q <= stage_valid_d;
            rr_q          <= rr_d;
            ovf_q         <= ovf_d;
        end
    end

    assign stage_result = {stage_q.tag, alu_exec(stage_q)};
    assign unused_op    = ^stage_q.op;

    alu_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (rst),
        .push_i      (stage_valid_q),
        .push_data_i (stage_result),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (unused_fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign cdb_valid    = !fifo_empty;
    assign cdb_tag      = fifo_head.tag;
    assign cdb_data     = fifo_head.data;
    assign busy         = (|pend_valid_q) || stage_valid_q || !fifo_empty;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: directed scenarios plus random traffic, compared
// every cycle against a queue-based reference of the issue/deliver behaviour.
module tb_alu_issue_unit;
    import tomasula_types::*;

    localparam int NUM_RS     = 4;
    localparam int FIFO_DEPTH = 2;

    logic                         clk = 1'b0;
    logic                         rst = 1'b0;
    logic [NUM_RS*ALU_WORD_W-1:0] rs_alu_data;
    logic [NUM_RS-1:0]            rs_start_exe = '0;
    logic                         cdb_ready = 1'b1;
    logic                         cdb_valid;
    logic [TAG_W-1:0]             cdb_tag;
    logic [XLEN-1:0]              cdb_data;
    logic                         busy;
    logic                         overflow_err;

    alu_word words [NUM_RS];

    for (genvar g = 0; g < NUM_RS; g++) begin : g_pack
        assign rs_alu_data[g*ALU_WORD_W +: ALU_WORD_W] = words[g];
    end

    alu_issue_unit #(
        .NUM_RS     (NUM_RS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rs_alu_data  (rs_alu_data),
        .rs_start_exe (rs_start_exe),
        .cdb_ready    (cdb_ready),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .busy         (busy),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    logic [34:0] exp_q[$];          // {tag, data} results visible at the CDB, head first
    bit          m_pend_v [NUM_RS];
    alu_word     m_pend   [NUM_RS];
    bit          m_stage_v;
    logic [34:0] m_stage_res;
    int          m_rr;
    bit          m_ovf;
    bit          m_just_reset;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at t=%0t: got=0x%0h expected=0x%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(alu_word w);
        int unsigned a  = w.src1_data;
        int unsigned b  = w.src2_data;
        int unsigned sh = w.src2_data % 32;
        int          sa = w.src1_data;
        int          sb = w.src2_data;
        case (w.funct3)
            3'd0:    return w.funct7 ? a - b : a + b;
            3'd1:    return a << sh;
            3'd2:    return (sa < sb) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return w.funct7 ? 32'(sa >>> sh) : a >> sh;
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic alu_word mk(input int tag, input int f3, input bit f7,
                                   input logic [31:0] a, input logic [31:0] b);
        alu_word w;
        w.op        = 7'h33;
        w.funct3    = 3'(f3);
        w.funct7    = f7;
        w.src1_data = a;
        w.src2_data = b;
        w.tag       = 3'(tag);
        return w;
    endfunction

    function automatic alu_word rand_word();
        alu_word w;
        w.op        = 7'($urandom_range(0, 127));
        w.funct3    = 3'($urandom_range(0, 7));
        w.funct7    = 1'($urandom_range(0, 1));
        w.src1_data = $urandom();
        w.src2_data = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom();
        w.tag       = 3'($urandom_range(0, 7));
        return w;
    endfunction

    // Applied at each rising edge with the inputs the DUT sees on that edge.
    task automatic model_edge();
        bit pop;
        int win;
        bit can_issue;
        if (!rst) begin
            exp_q.delete();
            for (int i = 0; i < NUM_RS; i++) m_pend_v[i] = 0;
            m_stage_v    = 0;
            m_rr         = 0;
            m_ovf        = 0;
            m_just_reset = 1;
            return;
        end
        m_just_reset = 0;
        pop = (exp_q.size() > 0) && cdb_ready;
        win = -1;
        for (int k = 0; k < NUM_RS; k++) begin
            if (win < 0 && m_pend_v[(m_rr + k) % NUM_RS]) win = (m_rr + k) % NUM_RS;
        end
        can_issue = (win >= 0) && (exp_q.size() + int'(m_stage_v) - int'(pop) < FIFO_DEPTH);
        if (pop) void'(exp_q.pop_front());
        if (m_stage_v) exp_q.push_back(m_stage_res);
        m_stage_v = can_issue;
        if (can_issue) begin
            m_stage_res   = {m_pend[win].tag, ref_alu(m_pend[win])};
            m_pend_v[win] = 0;
            m_rr          = (win + 1) % NUM_RS;
        end
        for (int i = 0; i < NUM_RS; i++) begin
            if (rs_start_exe[i]) begin
                if (m_pend_v[i]) begin
                    m_ovf = 1;
                end else begin
                    m_pend_v[i] = 1;
                    m_pend[i]   = words[i];
                end
            end
        end
    endtask

    task automatic check_outputs();
        bit any_pend = 0;
        for (int i = 0; i < NUM_RS; i++) any_pend |= m_pend_v[i];
        check_eq("fifo_bound", 64'(exp_q.size() <= FIFO_DEPTH), 64'd1);
        check_eq("cdb_valid", 64'(cdb_valid), 64'(exp_q.size() > 0));
        check_eq("busy", 64'(busy), 64'(any_pend || m_stage_v || exp_q.size() > 0));
        check_eq("overflow_err", 64'(overflow_err), 64'(m_ovf));
        if (exp_q.size() > 0) begin
            check_eq("cdb_tag", 64'(cdb_tag), 64'(exp_q[0][34:32]));
            check_eq("cdb_data", 64'(cdb_data), 64'(exp_q[0][31:0]));
        end else if (m_just_reset) begin
            check_eq("reset_tag", 64'(cdb_tag), 64'd0);
            check_eq("reset_data", 64'(cdb_data), 64'd0);
        end
    endtask

    // Inputs change only at the falling edge; outputs are checked there too.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        rs_start_exe = '0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse(input int st, input alu_word w);
        words[st]        = w;
        rs_start_exe[st] = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NUM_RS; i++) words[i] = '0;
        steps(2);
        rst = 1'b1;
        steps(1);

        // single add: result appears three cycles after the pulse
        cdb_ready = 1'b1;
        pulse(0, mk(3, 0, 0, 32'd5, 32'd7));
        steps(6);

        // all four stations at once
        pulse(0, mk(0, 0, 1, 32'd10, 32'd1));
        pulse(1, mk(1, 5, 1, 32'h8000_0000, 32'd4));
        pulse(2, mk(2, 3, 0, 32'd1, 32'd2));
        pulse(3, mk(3, 7, 0, 32'hF0, 32'h3C));
        steps(9);

        // backpressure then drain
        cdb_ready = 1'b0;
        pulse(0, mk(4, 4, 0, 32'hFF00, 32'h0FF0));
        pulse(1, mk(5, 1, 0, 32'd3, 32'd35));
        pulse(2, mk(6, 2, 0, 32'hFFFF_FFFE, 32'd1));
        steps(8);
        cdb_ready = 1'b1;
        steps(6);

        // two stations re-pulsing every third cycle
        for (int c = 0; c < 24; c++) begin
            if (c % 3 == 0) begin
                pulse(0, mk(c % 8, 0, 0, 32'(c), 32'd100));
                pulse(2, mk((c + 1) % 8, 6, 0, 32'(c), 32'h100));
            end
            step();
        end
        steps(5);

        // overflow on station 1 while its slot is still occupied
        cdb_ready = 1'b0;
        pulse(0, mk(0, 0, 0, 32'd1, 32'd1));
        pulse(2, mk(2, 0, 0, 32'd2, 32'd2));
        pulse(3, mk(3, 0, 0, 32'd3, 32'd3));
        step();
        pulse(1, mk(1, 0, 0, 32'd40, 32'd2));
        steps(2);
        pulse(1, mk(7, 0, 0, 32'd99, 32'd99));
        steps(4);
        cdb_ready = 1'b1;
        steps(8);

        // reset with work in flight
        cdb_ready = 1'b0;
        pulse(0, mk(1, 0, 0, 32'd11, 32'd1));
        pulse(1, mk(2, 0, 0, 32'd12, 32'd1));
        pulse(3, mk(4, 0, 0, 32'd13, 32'd1));
        steps(3);
        do_reset();
        cdb_ready = 1'b1;
        steps(6);

        // random traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NUM_RS; i++) begin
                if ($urandom_range(0, 3) == 0) pulse(i, rand_word());
            end
            cdb_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 149) != 0);
            step();
            rst = 1'b1;
        end
        cdb_ready = 1'b1;
        steps(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
